// File: rtl/single_port_lutram_arbiter_pkg.sv
// Shared types and constants for the single-port LUTRAM arbiter.
// Optional init sweep is enabled with LUTRAM_INIT_SWEEP_EN.
package single_port_lutram_arbiter_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;
  localparam int RESP_LATENCY     = 1;

  typedef enum logic {
    STATE_INIT  = 1'b0,
    STATE_SERVE = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/single_port_lutram_arbiter_if.sv
// Requester-side valid/ready bus for the LUTRAM arbiter.
// Requester i occupies slice i of every flattened field.
interface single_port_lutram_arbiter_if
  import single_port_lutram_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST                = 2,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = 6,
  parameter int WRITE_MASK_LEN             =
    SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
);
  localparam int N   = NUM_REQUEST;
  localparam int W   = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int SPW = SET_PTR_WIDTH_IN_BITS;
  localparam int WML = WRITE_MASK_LEN;

  logic [N-1:0]     request_valid_in;
  logic [N-1:0]     request_ready_out;
  logic [N*WML-1:0] request_write_en_in;
  logic [N*SPW-1:0] request_set_addr_in;
  logic [N*W-1:0]   request_write_entry_in;
  logic [N-1:0]     response_valid_out;
  logic [W-1:0]     response_entry_out;

  modport master (
    output request_valid_in,
    output request_write_en_in,
    output request_set_addr_in,
    output request_write_entry_in,
    input  request_ready_out,
    input  response_valid_out,
    input  response_entry_out
  );

  modport slave (
    input  request_valid_in,
    input  request_write_en_in,
    input  request_set_addr_in,
    input  request_write_entry_in,
    output request_ready_out,
    output response_valid_out,
    output response_entry_out
  );

endinterface

// File: rtl/single_port_lutram_arbiter_rr.sv
// Round-robin one-hot selector with its rotating pointer.
// Pointer moves past the winner on every grant and holds when idle.
module lutram_rr_arbiter
  import single_port_lutram_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 2,
  parameter int IDX_W       = idx_w(NUM_REQUEST)
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [NUM_REQUEST-1:0] i_req,
  output logic [NUM_REQUEST-1:0] o_grant,
  output logic [IDX_W-1:0]       o_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQUEST; k++) begin
      if (!w_found &&
          i_req[(int'(r_ptr) + k) % NUM_REQUEST]) begin
        w_found = 1'b1;
        o_idx   = IDX_W'((int'(r_ptr) + k) % NUM_REQUEST);
        o_grant[(int'(r_ptr) + k) % NUM_REQUEST] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= IDX_W'((int'(o_idx) + 1) % NUM_REQUEST);
    end
  end

endmodule

// File: rtl/single_port_lutram_arbiter.sv
// Shares one single-port LUTRAM among NUM_REQUEST requesters.
// Define LUTRAM_INIT_SWEEP_EN to zero all sets after reset.
module single_port_lutram_arbiter
  import single_port_lutram_arbiter_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             =
    SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int NUM_REQUEST                = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  single_port_lutram_arbiter_if.slave req_if,
  output logic lutram_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]
    lutram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]
    lutram_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]
    lutram_write_entry_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]
    lutram_read_entry_in
);

  localparam int N   = NUM_REQUEST;
  localparam int W   = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int SPW = SET_PTR_WIDTH_IN_BITS;
  localparam int WML = WRITE_MASK_LEN;
  localparam int IW  = idx_w(N);

  state_t           r_state;
  logic             w_init;
  logic             w_serve;
  logic [SPW-1:0]   w_sweep_addr;
  logic [N-1:0]     w_grant;
  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [WML-1:0]   w_mask;
  logic [SPW-1:0]   w_addr;
  logic [W-1:0]     w_data;
  logic [N-1:0]     w_rd_grant;
  logic [N-1:0]     r_tag [RESP_LATENCY];

`ifdef LUTRAM_INIT_SWEEP_EN
  logic [SPW-1:0] r_sweep;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= STATE_INIT;
      r_sweep <= '0;
    end else if (r_state == STATE_INIT) begin
      r_sweep <= r_sweep + 1'b1;
      if (r_sweep == SPW'(NUM_SET - 1)) begin
        r_state <= STATE_SERVE;
      end
    end
  end

  assign w_sweep_addr = r_sweep;
`else
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state <= STATE_SERVE;
    end else begin
      r_state <= STATE_SERVE;
    end
  end

  assign w_sweep_addr = '0;
`endif

  // Gated by reset so every output reads 0 while reset is held.
  assign w_init  = (r_state == STATE_INIT) & ~reset_in;
  assign w_serve = (r_state == STATE_SERVE) & ~reset_in;

  lutram_rr_arbiter #(
    .NUM_REQUEST (N),
    .IDX_W       (IW)
  ) u_arb (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_req    (req_if.request_valid_in & {N{w_serve}}),
    .o_grant  (w_grant),
    .o_idx    (w_idx)
  );

  assign w_any  = |w_grant;
  assign w_mask = w_any ?
    req_if.request_write_en_in[w_idx*WML +: WML] : '0;
  assign w_addr = w_any ?
    req_if.request_set_addr_in[w_idx*SPW +: SPW] : '0;
  assign w_data = w_any ?
    req_if.request_write_entry_in[w_idx*W +: W] : '0;

  assign req_if.request_ready_out = w_grant;

  assign lutram_access_en_out   = w_any | w_init;
  assign lutram_write_en_out    = w_init ? '1 : w_mask;
  assign lutram_set_addr_out    = w_init ? w_sweep_addr : w_addr;
  assign lutram_write_entry_out = w_init ? '0 : w_data;

  assign w_rd_grant = w_grant & {N{~|w_mask}};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_rd_grant;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign req_if.response_valid_out = r_tag[RESP_LATENCY-1];
  assign req_if.response_entry_out =
    (|r_tag[RESP_LATENCY-1]) ? lutram_read_entry_in : '0;

endmodule

// File: tb/tb_single_port_lutram_arbiter.sv
// Scoreboard bench for single_port_lutram_arbiter with a LUTRAM model.
// Sweep checks are included when LUTRAM_INIT_SWEEP_EN is defined.
module tb_single_port_lutram_arbiter;

  localparam int N   = 2;
  localparam int W   = 64;
  localparam int NS  = 64;
  localparam int SPW = 6;
  localparam int WML = 8;

  typedef struct {
    logic [N-1:0] vec;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb [$];

  logic           lut_acc;
  logic [WML-1:0] lut_we;
  logic [SPW-1:0] lut_addr;
  logic [W-1:0]   lut_wdata;
  logic [W-1:0]   lut_rd;
  logic [W-1:0]   mem [NS];

  single_port_lutram_arbiter_if #(
    .NUM_REQUEST                (N),
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .SET_PTR_WIDTH_IN_BITS      (SPW),
    .WRITE_MASK_LEN             (WML)
  ) bus ();

  single_port_lutram_arbiter #(
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .NUM_SET                    (NS),
    .SET_PTR_WIDTH_IN_BITS      (SPW),
    .WRITE_MASK_LEN             (WML),
    .NUM_REQUEST                (N)
  ) dut (
    .clk_in                 (clk),
    .reset_in               (rst),
    .req_if                 (bus),
    .lutram_access_en_out   (lut_acc),
    .lutram_write_en_out    (lut_we),
    .lutram_set_addr_out    (lut_addr),
    .lutram_write_entry_out (lut_wdata),
    .lutram_read_entry_in   (lut_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port LUTRAM: byte-masked write, registered read.
  always @(posedge clk) begin
    if (lut_acc) begin
      if (lut_we == '0) begin
        lut_rd <= mem[lut_addr];
      end else begin
        for (int b = 0; b < WML; b++) begin
          if (lut_we[b]) mem[lut_addr][b*8 +: 8] <= lut_wdata[b*8 +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (bus.response_valid_out != '0) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected valid=%b data=%h cyc=%0d",
                 bus.response_valid_out, bus.response_entry_out, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.response_valid_out !== e.vec ||
            bus.response_entry_out !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL resp got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                   bus.response_valid_out, bus.response_entry_out, cyc,
                   e.vec, e.data, e.cyc);
        end
      end
    end else if (bus.response_entry_out !== '0) begin
      miscompares++;
      $display("FAIL idle_entry got %h want 0", bus.response_entry_out);
    end
  end

  task automatic check_zero(input string name);
    logic [W*2+N*2+WML+SPW:0] all;
    all = {bus.request_ready_out, bus.response_valid_out,
           bus.response_entry_out, lut_acc, lut_we, lut_addr, lut_wdata};
    vectors++;
    if (all !== '0) begin
      miscompares++;
      $display("FAIL %s outputs got %h want 0", name, all);
    end
  endtask

  task automatic drive(input int i, input logic [WML-1:0] m,
                       input logic [SPW-1:0] a, input logic [W-1:0] d);
    bus.request_write_en_in[i*WML +: WML]  = m;
    bus.request_set_addr_in[i*SPW +: SPW]  = a;
    bus.request_write_entry_in[i*W +: W]   = d;
    bus.request_valid_in[i]                = 1'b1;
  endtask

  task automatic xfer(input int i, input logic [WML-1:0] m,
                      input logic [SPW-1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] exp_d, input bit keep);
    int n;
    logic [N-1:0] want;
    want = N'(1 << i);
    @(negedge clk);
    drive(i, m, a, d);
    #1;
    n = 0;
    while (bus.request_ready_out[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (bus.request_ready_out !== want) begin
      miscompares++;
      $display("FAIL grant req=%0d got %b want %b",
               i, bus.request_ready_out, want);
      bus.request_valid_in[i] = 1'b0;
      return;
    end
    vectors++;
    if ({lut_acc, lut_we, lut_addr, lut_wdata} !== {1'b1, m, a, d}) begin
      miscompares++;
      $display("FAIL lut_pins got %b %h %0d %h want 1 %h %0d %h",
               lut_acc, lut_we, lut_addr, lut_wdata, m, a, d);
    end
    if (m == '0 && keep) begin
      sb.push_back('{vec: want, data: exp_d, cyc: cyc + 1});
    end
    @(posedge clk);
    #1;
    bus.request_valid_in[i] = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g;
    int n;
    bus.request_valid_in       = '0;
    bus.request_write_en_in    = '0;
    bus.request_set_addr_in    = '0;
    bus.request_write_entry_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

`ifdef LUTRAM_INIT_SWEEP_EN
    drive(0, 8'h00, 6'd30, '0);
    #1;
    n = 0;
    while (bus.request_ready_out[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != NS) begin
      miscompares++;
      $display("FAIL init_len got %0d want %0d", n, NS);
    end
    sb.push_back('{vec: 2'b01, data: '0, cyc: cyc + 1});
    @(posedge clk);
    #1;
    bus.request_valid_in[0] = 1'b0;
`endif

    xfer(0, 8'hFF, 6'd63, 64'hFFFFFFFF00000000, '0, 1'b1);
    xfer(0, 8'h00, 6'd63, '0, 64'hFFFFFFFF00000000, 1'b1);

    xfer(0, 8'hFF, 6'd62, '0, '0, 1'b1);
    xfer(0, 8'b11001100, 6'd62, 64'hFFFFFFFFFFFFFFFF, '0, 1'b1);
    xfer(0, 8'h00, 6'd62, '0, 64'hFFFF0000FFFF0000, 1'b1);

    xfer(1, 8'hFF, 6'd7, 64'h0123456789ABCDEF, '0, 1'b1);
    xfer(0, 8'h00, 6'd7, '0, 64'h0123456789ABCDEF, 1'b1);

    xfer(0, 8'hFF, 6'd5, 64'h5555AAAA5555AAAA, '0, 1'b1);
    xfer(1, 8'hFF, 6'd9, 64'h9999666699996666, '0, 1'b1);

    @(negedge clk);
    drive(0, 8'h00, 6'd5, '0);
    drive(1, 8'h00, 6'd9, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      g = (c % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (bus.request_ready_out !== g) begin
        miscompares++;
        $display("FAIL rotate step=%0d got %b want %b",
                 c, bus.request_ready_out, g);
      end
      sb.push_back('{vec: g,
                     data: (c % 2 == 0) ? 64'h5555AAAA5555AAAA
                                        : 64'h9999666699996666,
                     cyc: cyc + 1});
      @(negedge clk);
    end
    bus.request_valid_in = '0;

    xfer(0, 8'h00, 6'd63, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_midop");
    @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_resp got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
